// File: rtl/etapa_fetch.sv
// Instruction fetch stage: PC, instruction memory with programming port, IF/ID register.
// Define FETCH_PERF_EN to add the fetch_count / stall_count performance counters.
module etapa_fetch #(
    parameter int          MEM_DEPTH = 256,
    parameter int          ADDR_W    = 8,
    parameter logic [31:0] PC_RESET  = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic              redirect,
    input  logic [31:0]       target,
    input  logic              prog_we,
    input  logic [ADDR_W-1:0] prog_addr,
    input  logic [31:0]       prog_data,
    output logic [31:0]       pc,
    output logic [31:0]       instr,
    output logic [31:0]       pc_plus4,
    output logic              valid,
`ifdef FETCH_PERF_EN
    output logic [5:0]        op,
    output logic [31:0]       fetch_count,
    output logic [31:0]       stall_count
`else
    output logic [5:0]        op
`endif
);

    logic [31:0]       mem_q [MEM_DEPTH];
    logic [ADDR_W-1:0] fetch_idx;
    logic [31:0]       fetch_word;

    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pc_plus4_q, pc_plus4_d;
    logic        valid_q, valid_d;

    // Upper PC bits are ignored, so any PC wraps onto the memory.
    assign fetch_idx  = pc_q[ADDR_W+1:2];
    assign fetch_word = mem_q[fetch_idx];

    always_comb begin
        pc_d       = pc_q;
        instr_d    = instr_q;
        pc_plus4_d = pc_plus4_q;
        valid_d    = valid_q;
        if (redirect) begin
            pc_d       = target & 32'hFFFF_FFFC;
            instr_d    = 32'h0;
            pc_plus4_d = 32'h0;
            valid_d    = 1'b0;
        end else if (!stall) begin
            pc_d       = pc_q + 32'd4;
            instr_d    = fetch_word;
            pc_plus4_d = pc_q + 32'd4;
            valid_d    = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q       <= PC_RESET;
            instr_q    <= 32'h0;
            pc_plus4_q <= 32'h0;
            valid_q    <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            instr_q    <= instr_d;
            pc_plus4_q <= pc_plus4_d;
            valid_q    <= valid_d;
        end
    end

    // Writes ignore reset; a same-edge fetch of this index still sees the old word.
    always_ff @(posedge clk) begin
        if (prog_we) begin
            mem_q[prog_addr] <= prog_data;
        end
    end

    assign pc       = pc_q;
    assign instr    = instr_q;
    assign pc_plus4 = pc_plus4_q;
    assign valid    = valid_q;
    assign op       = instr_q[31:26];

`ifdef FETCH_PERF_EN
    logic [31:0] fetch_count_q, fetch_count_d;
    logic [31:0] stall_count_q, stall_count_d;

    always_comb begin
        fetch_count_d = fetch_count_q;
        stall_count_d = stall_count_q;
        if (!redirect && !stall) begin
            fetch_count_d = fetch_count_q + 32'd1;
        end
        if (!redirect && stall) begin
            stall_count_d = stall_count_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_count_q <= 32'h0;
            stall_count_q <= 32'h0;
        end else begin
            fetch_count_q <= fetch_count_d;
            stall_count_q <= stall_count_d;
        end
    end

    assign fetch_count = fetch_count_q;
    assign stall_count = stall_count_q;
`endif

endmodule
